// File: rtl/traffic_controller.sv
// Two-road traffic light sequencer with an optional pedestrian walk phase.
// Walk is inserted at an all-red exit and then resumes the interrupted cycle.
module traffic_controller #(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 1,
  parameter int unsigned WALK_CYC   = 6,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic [0:2] light_a,
  output logic [0:2] light_b,
  output logic       walk,
  output logic [2:0] phase
);

  // state      | meaning
  // ST_A_GREEN | road A green, road B red
  // ST_A_YELLOW| road A yellow, road B red
  // ST_ALLRED_1| clearance before road B
  // ST_B_GREEN | road B green, road A red
  // ST_B_YELLOW| road B yellow, road A red
  // ST_ALLRED_2| clearance before road A
  // ST_WALK    | pedestrian walk, both roads red
  typedef enum logic [2:0] {
    ST_A_GREEN  = 3'd0,
    ST_A_YELLOW = 3'd1,
    ST_ALLRED_1 = 3'd2,
    ST_B_GREEN  = 3'd3,
    ST_B_YELLOW = 3'd4,
    ST_ALLRED_2 = 3'd5,
    ST_WALK     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_CYC - 1);

  localparam logic [0:2] LAMP_RED = 3'b100;
  localparam logic [0:2] LAMP_GRN = 3'b010;
  localparam logic [0:2] LAMP_YEL = 3'b001;

  // Raw 3-bit register so the unused code 7 is representable and recoverable.
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic             ret, ret_nxt;
  logic             ack, ack_nxt;
  logic             req_any;
  logic             walk_entry;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_A_GREEN;
      cnt   <= LD_GREEN;
      pend  <= 1'b0;
      ret   <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      ret   <= ret_nxt;
      ack   <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ret_nxt    = ret;
    ack_nxt    = ack;
    walk_entry = 1'b0;
    req_any    = pend | ped_req;

    if (state == 3'd7) begin
      // Recover regardless of enable so a corrupted code never lingers.
      state_nxt = ST_ALLRED_2;
      cnt_nxt   = LD_ALLRED;
      ack_nxt   = 1'b0;
    end else if (enable) begin
      ack_nxt = 1'b0;
      if (cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        case (state)
          ST_A_GREEN: begin
            state_nxt = ST_A_YELLOW;
            cnt_nxt   = LD_YELLOW;
          end
          ST_A_YELLOW: begin
            state_nxt = ST_ALLRED_1;
            cnt_nxt   = LD_ALLRED;
          end
          ST_ALLRED_1: begin
            if (req_any) begin
              state_nxt  = ST_WALK;
              cnt_nxt    = LD_WALK;
              walk_entry = 1'b1;
              ret_nxt    = 1'b0;
              ack_nxt    = 1'b1;
            end else begin
              state_nxt = ST_B_GREEN;
              cnt_nxt   = LD_GREEN;
            end
          end
          ST_B_GREEN: begin
            state_nxt = ST_B_YELLOW;
            cnt_nxt   = LD_YELLOW;
          end
          ST_B_YELLOW: begin
            state_nxt = ST_ALLRED_2;
            cnt_nxt   = LD_ALLRED;
          end
          ST_ALLRED_2: begin
            if (req_any) begin
              state_nxt  = ST_WALK;
              cnt_nxt    = LD_WALK;
              walk_entry = 1'b1;
              ret_nxt    = 1'b1;
              ack_nxt    = 1'b1;
            end else begin
              state_nxt = ST_A_GREEN;
              cnt_nxt   = LD_GREEN;
            end
          end
          ST_WALK: begin
            state_nxt = ret ? ST_A_GREEN : ST_B_GREEN;
            cnt_nxt   = LD_GREEN;
          end
          default: begin
            state_nxt = ST_ALLRED_2;
            cnt_nxt   = LD_ALLRED;
          end
        endcase
      end
    end

    pend_nxt = req_any & ~walk_entry;
  end

  always_comb begin
    light_a = LAMP_RED;
    light_b = LAMP_RED;
    walk    = 1'b0;
    case (state)
      ST_A_GREEN:  light_a = LAMP_GRN;
      ST_A_YELLOW: light_a = LAMP_YEL;
      ST_B_GREEN:  light_b = LAMP_GRN;
      ST_B_YELLOW: light_b = LAMP_YEL;
      ST_WALK:     walk    = 1'b1;
      default: ;
    endcase
  end

  assign phase   = state;
  assign ped_ack = ack;

endmodule
